// File: rtl/approx_mul_pipe_pkg.sv
// approx_mul_pipe_pkg
//   Shared definitions for the pipelined quadrant-split approximate multiplier.
//   - Q_LL/Q_LH/Q_HL/Q_HH: quadrant indices, also the bit positions of each
//     quadrant's approximate flag inside a mode word.
//   - mode_t: 4-bit quadrant mode word (1 = approximate).
//   - approx_mask(): mask that clears the TRUNC low bits of a sub-product.
package approx_mul_pipe_pkg;

  localparam int Q_LL     = 0;
  localparam int Q_LH     = 1;
  localparam int Q_HL     = 2;
  localparam int Q_HH     = 3;
  localparam int NUM_QUAD = 4;

  // Widest sub-product the mask helper can describe; callers slice it down.
  localparam int MASK_W = 64;

  typedef logic [NUM_QUAD-1:0] mode_t;

  // Bit i is kept when i >= trunc, so the low 'trunc' bits are forced to zero.
  function automatic logic [MASK_W-1:0] approx_mask(input int trunc);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i >= trunc);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_mul_half.sv
// approx_mul_half
//   H x H unsigned multiplier producing a 2H-bit sub-product. When 'approx'
//   is high the TRUNC least-significant product bits are forced to zero.
//   Purely combinational; the caller registers the result.
// Ports:
//   a, b    in   H    unsigned operands
//   approx  in   1    1 = truncated-approximate, 0 = exact
//   p       out  2H   sub-product
module approx_mul_half
  import approx_mul_pipe_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam int PW = 2 * H;

  localparam logic [MASK_W-1:0] FULL_MASK = approx_mask(TRUNC);
  localparam logic [PW-1:0]     MASK      = FULL_MASK[PW-1:0];

  logic [PW-1:0] exact;

  // Operands are widened first so the product is computed at full 2H width.
  assign exact = PW'(a) * PW'(b);
  assign p     = approx ? (exact & MASK) : exact;

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe
//   Pipelined W x W unsigned approximate multiplier. Each operand is split
//   into high/low halves; the four half-width sub-products HH, HL, LH, LL are
//   each exact or truncated according to the mode word captured with the
//   operand pair, then combined by shift-add into a 2W-bit product.
//   Three register stages (operands, sub-products, product) with a
//   valid/ready handshake on both sides and full backpressure.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous reset, active-high
//   cfg_we     in   1    load cfg_mode into the mode register
//   cfg_mode   in   4    new quadrant mode (bit0=LL, bit1=LH, bit2=HL, bit3=HH)
//   mode       out  4    current mode register
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    operand pair accepted this cycle when in_valid
//   in_a, in_b in   W    unsigned operands
//   out_valid  out  1    product valid
//   out_ready  in   1    consumer takes the product this cycle
//   out_prod   out  2W   product
//   busy       out  1    some stage holds a valid entry
module approx_mul_pipe
  import approx_mul_pipe_pkg::*;
#(
  parameter int          W            = 8,
  parameter int          TRUNC        = 2,
  parameter logic [3:0]  DEFAULT_MODE = 4'b1110
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_mode,
  output logic [3:0]     mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod,
  output logic           busy
);

  localparam int H  = W / 2;
  localparam int QW = 2 * H;
  localparam int PW = 2 * W;

  mode_t         mode_q;

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  mode_t         s1_mode;

  logic          s2_valid;
  logic [QW-1:0] s2_pp [NUM_QUAD];

  logic          s3_valid;
  logic [PW-1:0] s3_prod;

  logic          s1_free;
  logic          s2_free;
  logic          s3_free;

  logic [H-1:0]  qa [NUM_QUAD];
  logic [H-1:0]  qb [NUM_QUAD];
  logic [QW-1:0] pp [NUM_QUAD];
  logic [PW-1:0] sum;

  // A stage may load when it is empty or its content leaves this cycle.
  // The chain runs backwards from out_ready, so in_ready depends on
  // out_ready combinationally but never on in_valid.
  assign s3_free  = !s3_valid || out_ready;
  assign s2_free  = !s2_valid || s3_free;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = s1_free;

  assign out_valid = s3_valid;
  assign out_prod  = s3_prod;
  assign busy      = s1_valid || s2_valid || s3_valid;
  assign mode      = mode_q;

  // Mode register. An entry accepted on the same edge as a cfg_we write
  // captures the old value because S1 samples mode_q before it updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= DEFAULT_MODE;
    end else if (cfg_we) begin
      mode_q <= cfg_mode;
    end
  end

  // S1: operand pair plus the mode in force at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (s1_free) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= mode_q;
      end
    end
  end

  // Quadrant operand routing: HL pairs a_hi with b_lo, LH pairs a_lo with b_hi.
  assign qa[Q_LL] = s1_a[H-1:0];
  assign qb[Q_LL] = s1_b[H-1:0];
  assign qa[Q_LH] = s1_a[H-1:0];
  assign qb[Q_LH] = s1_b[W-1:H];
  assign qa[Q_HL] = s1_a[W-1:H];
  assign qb[Q_HL] = s1_b[H-1:0];
  assign qa[Q_HH] = s1_a[W-1:H];
  assign qb[Q_HH] = s1_b[W-1:H];

  for (genvar q = 0; q < NUM_QUAD; q++) begin : g_quad
    approx_mul_half #(
      .H     (H),
      .TRUNC (TRUNC)
    ) u_half (
      .a      (qa[q]),
      .b      (qb[q]),
      .approx (s1_mode[q]),
      .p      (pp[q])
    );
  end

  // S2: the four sub-products, already truncated where the mode asks for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      for (int q = 0; q < NUM_QUAD; q++) begin
        s2_pp[q] <= '0;
      end
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int q = 0; q < NUM_QUAD; q++) begin
          s2_pp[q] <= pp[q];
        end
      end
    end
  end

  // Shift-add at full 2W width; the exact product bounds the sum, and
  // truncation only lowers it, so nothing carries out of the top bit.
  assign sum = (PW'(s2_pp[Q_HH]) << W)
             + ((PW'(s2_pp[Q_HL]) + PW'(s2_pp[Q_LH])) << H)
             + PW'(s2_pp[Q_LL]);

  // S3: final product. Holding while stalled keeps out_prod stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_prod  <= '0;
    end else if (s3_free) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_prod <= sum;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe
//   Self-checking bench for approx_mul_pipe with W=8, TRUNC=2. A scoreboard
//   of expected products (from an arithmetic reference model that uses the
//   per-entry mode) is compared with every product the DUT hands out.
module tb_approx_mul_pipe;

  localparam int         W     = 8;
  localparam int         TRUNC = 2;
  localparam logic [3:0] DEF   = 4'b1110;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_mode;
  logic [3:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        busy;

  approx_mul_pipe #(
    .W            (W),
    .TRUNC        (TRUNC),
    .DEFAULT_MODE (DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  m;
    int          acc_step;
  } entry_t;

  entry_t      sb[$];
  logic [15:0] hist[$];
  int          tests = 0;
  int          fails = 0;
  int          step_no = 0;
  int          last_latency = 0;
  logic [15:0] last_out = '0;
  logic [3:0]  model_mode = DEF;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_prod = '0;

  // Reference: split into nibbles, multiply, round approximate quadrants
  // down to a multiple of 2^TRUNC, recombine by weights 256/16/1.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] m);
    int unsigned ah, al, bh, bl, total;
    int unsigned p[4];
    ah = a / 16; al = a % 16; bh = b / 16; bl = b % 16;
    p[0] = al * bl;
    p[1] = al * bh;
    p[2] = ah * bl;
    p[3] = ah * bh;
    for (int q = 0; q < 4; q++) begin
      if (m[q]) p[q] = p[q] - (p[q] % (1 << TRUNC));
    end
    total = p[3] * 256 + (p[1] + p[2]) * 16 + p[0];
    return total[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, step_no);
    end
  endtask

  // One cycle: drive inputs just after a falling edge, sample, update the
  // model for the transfers the coming rising edge will perform.
  task automatic applyStimulus(input logic r, input logic iv, input logic [7:0] a,
                               input logic [7:0] b, input logic ordy, input logic cwe,
                               input logic [3:0] cm, output logic accepted);
    entry_t e;
    rst = r; in_valid = iv; in_a = a; in_b = b;
    out_ready = ordy; cfg_we = cwe; cfg_mode = cm;
    #1;
    accepted = 1'b0;
    if (!r) begin
      checkOutput("mode", 32'(mode), 32'(model_mode));
      checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
      if (prev_stall) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdProd", 32'(out_prod), 32'(prev_prod));
      end
      if (sb.size() == 0) checkOutput("noStale", 32'(out_valid), 32'd0);
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("prod", 32'(out_prod), 32'(e.prod));
        if (e.m == 4'b0000) checkOutput("exact", 32'(out_prod), 32'(e.a) * 32'(e.b));
        last_out = out_prod;
        last_latency = step_no - e.acc_step;
        hist.push_back(out_prod);
      end
      if (in_valid && in_ready) begin
        e.prod = ref_prod(a, b, model_mode);
        e.a = a; e.b = b; e.m = model_mode; e.acc_step = step_no;
        sb.push_back(e);
        accepted = 1'b1;
      end
      if (cwe) model_mode = cm;
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_prod;
    end else begin
      sb.delete();
      model_mode = DEF;
      prev_stall = 1'b0;
    end
    @(negedge clk);
    step_no++;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    int   n_acc;
    int   guard;
    rst = 1'b1; cfg_we = 1'b0; cfg_mode = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstProd", 32'(out_prod), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstMode", 32'(mode), 32'(DEF));
    checkOutput("rstInReady", 32'(in_ready), 32'd1);

    // Default mode 1110, 0xFF * 0xFF
    applyStimulus(0, 1, 8'hFF, 8'hFF, 1, 0, 0, acc);
    repeat (4) applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
    checkOutput("katDefault", 32'(last_out), 32'h0000FCE1);
    checkOutput("latDefault", 32'(last_latency), 32'd3);

    // Exact mode 0000
    applyStimulus(0, 0, 0, 0, 1, 1, 4'b0000, acc);
    applyStimulus(0, 1, 8'hFF, 8'hFF, 1, 0, 0, acc);
    repeat (4) applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
    checkOutput("katExact", 32'(last_out), 32'h0000FE01);
    checkOutput("latExact", 32'(last_latency), 32'd3);

    // Mode 1111, then cfg_we coinciding with an accept keeps the old mode
    applyStimulus(0, 0, 0, 0, 1, 1, 4'b1111, acc);
    hist.delete();
    applyStimulus(0, 1, 8'hFF, 8'hFF, 1, 1, 4'b0000, acc);
    applyStimulus(0, 1, 8'hFF, 8'hFF, 1, 0, 0, acc);
    repeat (4) applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
    checkOutput("cfgCount", 32'(hist.size()), 32'd2);
    checkOutput("cfgOldMode", 32'(hist[0]), 32'h0000FCE0);
    checkOutput("cfgNewMode", 32'(hist[1]), 32'h0000FE01);

    // Backpressure: out_ready low for 6 cycles while offering a=1..5, b=3
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, idx < 5, 8'(idx + 1), 8'd3, 0, 0, 0, acc);
      if (acc) idx++;
    end
    checkOutput("bpAccepted", 32'(idx), 32'd3);
    checkOutput("bpInReady", 32'(in_ready), 32'd0);
    hist.delete();
    guard = 0;
    while ((idx < 5 || sb.size() != 0) && guard < 30) begin
      applyStimulus(0, idx < 5, 8'(idx + 1), 8'd3, 1, 0, 0, acc);
      if (acc) idx++;
      guard++;
    end
    checkOutput("bpCount", 32'(hist.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpOrder", 32'(hist[i]), 32'(3 * (i + 1)));
    end

    // Reset with three entries in flight, cfg_we in the same cycle loses
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, 8'($urandom), 8'($urandom), 0, 0, 0, acc);
    end
    checkOutput("fillBusy", 32'(busy), 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 1, 4'b0101, acc);
    checkOutput("midRstValid", 32'(out_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstMode", 32'(mode), 32'(DEF));
    repeat (5) applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);

    // Random traffic, random handshakes and occasional mode changes
    n_acc = 0;
    guard = 0;
    while (n_acc < 10000 && guard < 60000) begin
      applyStimulus(0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    4'($urandom), acc);
      if (acc) n_acc++;
      guard++;
    end
    checkOutput("randAccepted", 32'(n_acc), 32'd10000);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
      guard++;
    end
    checkOutput("randDrained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
